// File: rtl/accel_spi_reader.sv
// accel_spi_reader: SPI mode-0 master for an ADXL362-class accelerometer.
// Writes POWER_CTL once to enable measurement, then burst-reads XL..YH on a
// fixed launch period and publishes the 12-bit X/Y samples.
module accel_spi_reader #(
   parameter int CLK_DIV       = 50,
   parameter int SAMPLE_PERIOD = 100000,
   parameter int CS_GAP        = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        miso,
   output logic        sclk,
   output logic        mosi,
   output logic        cs_n,
   output logic [11:0] x_acc,
   output logic [11:0] y_acc,
   output logic        data_valid,
   output logic        init_done
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int GAP_W = $clog2(CS_GAP + 1);
   localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(CS_GAP - 1);
   localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(SAMPLE_PERIOD - 1);

   localparam logic [23:0] CFG_HDR  = 24'h0A2D02;
   localparam logic [23:0] READ_HDR = 24'h0B0E00;
   localparam logic [5:0]  CFG_LAST = 6'd23;
   localparam logic [5:0]  RD_LAST  = 6'd47;

   typedef enum logic [2:0] {
      ST_INIT_GAP,
      ST_CFG,
      ST_GAP,
      ST_WAIT,
      ST_READ,
      ST_UPDATE
   } state_t;

   typedef enum logic [1:0] {
      PH_LEAD,
      PH_LOW,
      PH_HIGH,
      PH_TRAIL
   } phase_t;

   state_t           state_q, state_d;
   phase_t           ph_q, ph_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [5:0]       bit_q, bit_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic [23:0]      tx_q, tx_d;
   logic [23:0]      rx_q, rx_d;
   logic             sclk_d, mosi_d, cs_n_d;
   logic [11:0]      x_d, y_d;
   logic             dv_d, init_d;
   logic             launch_cfg, launch_rd;
   logic             rx_keep;
   logic [5:0]       last_bit;

   // Only the 24 payload bits are shifted in: XL, XH[3:0], YL, YH[3:0].
   // Bytes 0-1 and the high nibbles of bytes 3 and 5 are skipped.
   assign rx_keep  = (bit_q >= 6'd16) &&
                     !(((bit_q[5:3] == 3'd3) || (bit_q[5:3] == 3'd5)) && !bit_q[2]);
   assign last_bit = (state_q == ST_CFG) ? CFG_LAST : RD_LAST;

   // State, counters and registered SPI/sample outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_INIT_GAP;
         ph_q       <= PH_LEAD;
         div_q      <= '0;
         bit_q      <= '0;
         gap_q      <= '0;
         tmr_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         sclk       <= 1'b0;
         mosi       <= 1'b0;
         cs_n       <= 1'b1;
         x_acc      <= '0;
         y_acc      <= '0;
         data_valid <= 1'b0;
         init_done  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         gap_q      <= gap_d;
         tmr_q      <= tmr_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         sclk       <= sclk_d;
         mosi       <= mosi_d;
         cs_n       <= cs_n_d;
         x_acc      <= x_d;
         y_acc      <= y_d;
         data_valid <= dv_d;
         init_done  <= init_d;
      end
   end

   // Next-state, bit engine, sample timer and output decode.
   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      div_d      = div_q;
      bit_d      = bit_q;
      gap_d      = gap_q;
      tmr_d      = tmr_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      sclk_d     = sclk;
      mosi_d     = mosi;
      cs_n_d     = cs_n;
      x_d        = x_acc;
      y_d        = y_acc;
      dv_d       = 1'b0;
      init_d     = init_done;
      launch_cfg = 1'b0;
      launch_rd  = 1'b0;

      if ((state_q != ST_INIT_GAP) && (state_q != ST_CFG)) begin
         tmr_d = (tmr_q == '0) ? '0 : tmr_q - 1'b1;
      end

      case (state_q)
         ST_INIT_GAP: begin
            if (gap_q == GAP_LAST) launch_cfg = 1'b1;
            else                   gap_d = gap_q + 1'b1;
         end

         // UPDATE is the first cs_n-high cycle, so it counts toward the gap;
         // a due read launches straight out of the last gap cycle.
         ST_GAP, ST_UPDATE: begin
            if (gap_q == GAP_LAST) begin
               if (tmr_q == '0) launch_rd = 1'b1;
               else             state_d = ST_WAIT;
            end else begin
               gap_d   = gap_q + 1'b1;
               state_d = ST_GAP;
            end
         end

         ST_WAIT: begin
            if (tmr_q == '0) launch_rd = 1'b1;
         end

         ST_CFG, ST_READ: begin
            case (ph_q)
               PH_LEAD: begin
                  ph_d   = PH_LOW;
                  div_d  = '0;
                  mosi_d = tx_q[23];
                  tx_d   = {tx_q[22:0], 1'b0};
               end
               PH_LOW: begin
                  if (div_q == DIV_LAST) begin
                     div_d  = '0;
                     ph_d   = PH_HIGH;
                     sclk_d = 1'b1;
                     if ((state_q == ST_READ) && rx_keep) rx_d = {rx_q[22:0], miso};
                  end else begin
                     div_d = div_q + 1'b1;
                  end
               end
               PH_HIGH: begin
                  if (div_q == DIV_LAST) begin
                     div_d  = '0;
                     sclk_d = 1'b0;
                     if (bit_q == last_bit) begin
                        ph_d = PH_TRAIL;
                     end else begin
                        bit_d  = bit_q + 1'b1;
                        ph_d   = PH_LOW;
                        mosi_d = tx_q[23];
                        tx_d   = {tx_q[22:0], 1'b0};
                     end
                  end else begin
                     div_d = div_q + 1'b1;
                  end
               end
               default: begin
                  cs_n_d = 1'b1;
                  mosi_d = 1'b0;
                  gap_d  = '0;
                  if (state_q == ST_CFG) begin
                     init_d  = 1'b1;
                     tmr_d   = '0;
                     state_d = ST_GAP;
                  end else begin
                     x_d     = {rx_q[15:12], rx_q[23:16]};
                     y_d     = {rx_q[3:0], rx_q[11:4]};
                     dv_d    = 1'b1;
                     state_d = ST_UPDATE;
                  end
               end
            endcase
         end

         default: state_d = ST_INIT_GAP;
      endcase

      if (launch_cfg || launch_rd) begin
         state_d = launch_cfg ? ST_CFG : ST_READ;
         ph_d    = PH_LEAD;
         div_d   = '0;
         bit_d   = '0;
         gap_d   = '0;
         cs_n_d  = 1'b0;
         sclk_d  = 1'b0;
         mosi_d  = 1'b0;
         tx_d    = launch_cfg ? CFG_HDR : READ_HDR;
         if (launch_rd) tmr_d = TMR_RELOAD;
      end
   end

endmodule

// File: tb/tb_accel_spi_reader.sv
// tb_accel_spi_reader: randomized slave model and timing checks for
// accel_spi_reader; a second instance with a short period checks gaps.
module tb_accel_spi_reader;

   localparam int CLK_DIV       = 2;
   localparam int CS_GAP        = 4;
   localparam int SAMPLE_PERIOD = 400;
   localparam int FAST_PERIOD   = 10;
   localparam int CFG_LOW       = 48 * CLK_DIV + 2;
   localparam int RD_LOW        = 96 * CLK_DIV + 2;

   logic        clk, rst, miso, sclk, mosi, cs_n, data_valid, init_done;
   logic [11:0] x_acc, y_acc;
   logic        f_miso = 1'b1;
   logic        f_sclk, f_mosi, f_cs_n, f_dv, f_init;
   logic [11:0] f_x, f_y;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  resp   [6];
   logic [7:0]  exp_tx [6];
   logic [7:0]  cap    [6];
   int          cap_bits;
   logic [11:0] exp_x, exp_y;

   accel_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD), .CS_GAP(CS_GAP)) dut (
      .clk(clk), .rst(rst), .miso(miso), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .x_acc(x_acc), .y_acc(y_acc), .data_valid(data_valid), .init_done(init_done)
   );

   accel_spi_reader #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(FAST_PERIOD), .CS_GAP(CS_GAP)) dut_fast (
      .clk(clk), .rst(rst), .miso(f_miso), .sclk(f_sclk), .mosi(f_mosi), .cs_n(f_cs_n),
      .x_acc(f_x), .y_acc(f_y), .data_valid(f_dv), .init_done(f_init)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Runs while cs_n is high: randomizes miso and requires held outputs.
   task automatic wait_low(input string tag, output int hi);
      int bad = 0;
      hi = 0;
      while (cs_n === 1'b1 && hi < 2000) begin
         hi++;
         if (data_valid !== 1'b0 || x_acc !== exp_x || y_acc !== exp_y || sclk !== 1'b0) bad++;
         miso = 1'($urandom);
         @(negedge clk);
      end
      check_eq({tag, "_cs_fall"}, {31'd0, cs_n}, 0);
      check_eq({tag, "_hold"}, bad, 0);
   endtask

   // Entered at the first cs_n-low sample; acts as the SPI slave.
   task automatic txn(input string tag, input int nbytes);
      int  fb = 0;
      int  low = 0;
      logic sclk_p = 1'b0;
      cap_bits = 0;
      for (int i = 0; i < 6; i++) cap[i] = '0;
      miso = resp[0][7];
      while (cs_n === 1'b0 && low < 4000) begin
         low++;
         if (sclk && !sclk_p) begin
            if (cap_bits < 48) cap[cap_bits / 8][7 - cap_bits % 8] = mosi;
            cap_bits++;
         end
         if (!sclk && sclk_p) begin
            fb++;
            if (fb < nbytes * 8) miso = resp[fb / 8][7 - fb % 8];
            else                 miso = 1'($urandom);
         end
         sclk_p = sclk;
         @(negedge clk);
      end
      check_eq({tag, "_cs_rise"}, {31'd0, cs_n}, 1);
      check_eq({tag, "_low_len"}, low, (nbytes == 3) ? CFG_LOW : RD_LOW);
      check_eq({tag, "_bits"}, cap_bits, nbytes * 8);
      for (int i = 0; i < nbytes; i++)
         check_eq($sformatf("%s_mosi%0d", tag, i), {24'd0, cap[i]}, {24'd0, exp_tx[i]});
   endtask

   task automatic do_cfg(input string tag);
      exp_tx[0] = 8'h0A; exp_tx[1] = 8'h2D; exp_tx[2] = 8'h02;
      for (int i = 0; i < 6; i++) resp[i] = 8'($urandom);
      check_eq({tag, "_init_before"}, {31'd0, init_done}, 0);
      txn(tag, 3);
      check_eq({tag, "_init_done"}, {31'd0, init_done}, 1);
      check_eq({tag, "_no_dv"}, {31'd0, data_valid}, 0);
   endtask

   // Fast instance: every gap after configuration is exactly CS_GAP; the
   // all-ones slave must read back as 0xFFF on both axes.
   int          f_hi = 0, f_gaps = 0, f_nb = 0, f_idle_bad = 0, f_samples = 0;
   logic        f_cs_p = 1'b1, f_sclk_p = 1'b0, f_kind = 1'b0, f_dv_p = 1'b0;
   logic [7:0]  f_byte = '0;
   always @(negedge clk) begin
      if (rst) begin
         f_hi = 0; f_cs_p = 1'b1; f_sclk_p = 1'b0; f_dv_p = 1'b0;
      end else begin
         if (f_cs_n) begin
            if (!f_cs_p) check_eq("fast_cmd", {24'd0, f_byte}, f_kind ? 32'h0B : 32'h0A);
            f_hi++;
            if (f_sclk !== 1'b0) f_idle_bad++;
         end else begin
            if (f_cs_p) begin
               if (f_init) begin
                  check_eq("fast_gap", f_hi, CS_GAP);
                  f_gaps++;
               end
               f_kind = f_init; f_nb = 0; f_byte = '0;
            end
            if (f_sclk && !f_sclk_p && f_nb < 8) begin
               f_byte = {f_byte[6:0], f_mosi};
               f_nb++;
            end
            f_hi = 0;
         end
         if (f_dv) begin
            check_eq("fast_x", {20'd0, f_x}, 32'hFFF);
            check_eq("fast_y", {20'd0, f_y}, 32'hFFF);
            check_eq("fast_dv_pulse", {31'd0, f_dv_p}, 0);
            f_samples++;
         end
         f_cs_p = f_cs_n; f_sclk_p = f_sclk; f_dv_p = f_dv;
      end
   end

   // Main sequence.
   initial begin
      int   hi, fb, guard;
      logic sclk_p;
      time  t_prev;
      rst = 1'b1; miso = 1'b0; exp_x = '0; exp_y = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_sclk", {31'd0, sclk}, 0);
      check_eq("rst_cs_n", {31'd0, cs_n}, 1);
      check_eq("rst_mosi", {31'd0, mosi}, 0);
      check_eq("rst_x", {20'd0, x_acc}, 0);
      check_eq("rst_y", {20'd0, y_acc}, 0);
      check_eq("rst_dv", {31'd0, data_valid}, 0);
      check_eq("rst_init", {31'd0, init_done}, 0);
      wait_low("init", hi);
      check_eq("init_gap", hi, CS_GAP);
      do_cfg("cfg");
      wait_low("gap0", hi);
      check_eq("cfg_to_read_gap", hi, CS_GAP);
      t_prev = $time;

      for (int r = 0; r < 6; r++) begin
         exp_tx[0] = 8'h0B; exp_tx[1] = 8'h0E;
         for (int i = 2; i < 6; i++) exp_tx[i] = 8'h00;
         for (int i = 0; i < 6; i++) resp[i] = 8'($urandom);
         if (r == 0) begin
            resp[2] = 8'h34; resp[3] = 8'h02; resp[4] = 8'hF0; resp[5] = 8'hFF;
         end else if (r == 1) begin
            resp[2] = 8'h00; resp[3] = 8'h35; resp[4] = 8'h00; resp[5] = 8'hF8;
         end
         txn($sformatf("rd%0d", r), 6);
         exp_x = 12'((int'(resp[3]) % 16) * 256 + int'(resp[2]));
         exp_y = 12'((int'(resp[5]) % 16) * 256 + int'(resp[4]));
         check_eq($sformatf("rd%0d_dv", r), {31'd0, data_valid}, 1);
         check_eq($sformatf("rd%0d_x", r), {20'd0, x_acc}, {20'd0, exp_x});
         check_eq($sformatf("rd%0d_y", r), {20'd0, y_acc}, {20'd0, exp_y});
         @(negedge clk);
         check_eq($sformatf("rd%0d_dv_end", r), {31'd0, data_valid}, 0);
         wait_low($sformatf("wait%0d", r), hi);
         check_eq($sformatf("period%0d", r), int'(($time - t_prev) / 10), SAMPLE_PERIOD);
         t_prev = $time;
      end

      // Abort the next read in the middle of byte 4.
      fb = 0; guard = 0; sclk_p = 1'b0;
      while (fb < 28 && guard < 4000) begin
         guard++;
         if (!sclk && sclk_p) fb++;
         sclk_p = sclk;
         miso = 1'($urandom);
         @(negedge clk);
      end
      check_eq("abort_in_txn", {31'd0, cs_n}, 0);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_cs_n", {31'd0, cs_n}, 1);
      check_eq("abort_sclk", {31'd0, sclk}, 0);
      check_eq("abort_x", {20'd0, x_acc}, 0);
      check_eq("abort_y", {20'd0, y_acc}, 0);
      check_eq("abort_init", {31'd0, init_done}, 0);
      check_eq("abort_dv", {31'd0, data_valid}, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      exp_x = '0; exp_y = '0;
      @(negedge clk);
      wait_low("reinit", hi);
      check_eq("reinit_gap", hi, CS_GAP);
      do_cfg("recfg");

      check_eq("fast_gaps_seen", {31'd0, f_gaps > 0}, 1);
      check_eq("fast_samples_seen", {31'd0, f_samples > 0}, 1);
      check_eq("fast_sclk_idle", f_idle_bad, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
